branch_resolve_queue: RTL
=========================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001: Parameter DEPTH, default 8, number of in-flight branch entries; power of two, at least 2.
REQ-002: Parameter CNT_NBITS, default 32, width of each statistics counter.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: pred_val  input  1  enqueue request for a newly predicted branch.
REQ-006: pred_rdy  output  1  queue can accept an entry (not full).
REQ-007: pred_pc  input  32  PC of the predicted branch.
REQ-008: pred_taken  input  1  prediction bit from the gshare predictor.
REQ-009: res_val  input  1  resolution of the oldest in-flight branch is available.
REQ-010: res_rdy  output  1  queue holds at least one entry (not empty).
REQ-011: res_taken  input  1  actual branch outcome.
REQ-012: upd_en  output  1  drives the predictor update_en.
REQ-013: upd_val  output  1  drives the predictor update_val.
REQ-014: upd_pc  output  32  drives the predictor PC during an update.
REQ-015: mispredict  output  1  one-cycle pulse indicating that the resolved branch was mispredicted.
REQ-016: occupancy  output  $clog2(DEPTH)+1  current number of valid entries.
REQ-017: cnt_branches  output  CNT_NBITS  total resolved branches.
REQ-018: cnt_mispred  output  CNT_NBITS  total mispredicted branches.

Function
REQ-019: Storage SHALL be a circular FIFO of DEPTH entries {pc[31:0], taken}, with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-020: Enqueue fires when pred_val && pred_rdy and writes {pred_pc, pred_taken} at the tail.
REQ-021: pred_rdy SHALL be 1 when occupancy < DEPTH; it has no same-cycle bypass and depends only on state.
REQ-022: Resolve fires when res_val && res_rdy and pops the head entry; res_rdy SHALL be 1 when occupancy > 0.
REQ-023: res_val while the queue is empty SHALL be ignored, with no counter or output change.
REQ-024: pred_val while the queue is full SHALL be ignored, with no entry written.
REQ-025: When enqueue and resolve fire in the same cycle without a mispredict, both SHALL take effect and occupancy SHALL be unchanged.
REQ-026: On a resolve fire, the cycle after SHALL present upd_en=1, upd_val=res_taken, upd_pc=head.pc, all registered; upd_en SHALL be 0 in all other cycles.
REQ-027: A resolve fire where res_taken != head.taken SHALL assert mispredict on the same registered cycle as upd_en.
REQ-028: On a mispredict resolve, all entries younger than the head SHALL be flushed in that same cycle (occupancy becomes 0 next cycle), and any same-cycle enqueue SHALL be discarded.
REQ-029: upd_pc and upd_val SHALL hold their last values when upd_en=0.
REQ-030: cnt_branches SHALL increment by 1 per resolve fire, and cnt_mispred by 1 per mispredicting resolve fire; both SHALL saturate at all-ones.
REQ-031: occupancy SHALL be a registered count, consistent with the pointers at all times, including across pointer wrap-around.

Reset
REQ-032: While reset is high, regardless of clk: head=tail=0, occupancy=0, pred_rdy=1, res_rdy=0, upd_en=0, upd_val=0, upd_pc=0, mispredict=0, cnt_branches=0, cnt_mispred=0.
REQ-033: Reset asserted mid-operation SHALL discard all entries and abort any pending update, so upd_en is 0 on the edge after reset deasserts.
REQ-034: Entry storage contents need not be reset.

Verification
REQ-035: After reset, enqueue PC 0x100 taken=1, then resolve taken=1 -> next cycle upd_en=1, upd_pc=0x100, upd_val=1, mispredict=0, cnt_branches=1.
REQ-036: Fill with DEPTH=8 entries -> pred_rdy=0, occupancy=8; a 9th pred_val is dropped; 8 resolves return PCs in enqueue order.
REQ-037: Enqueue 0x200 (taken=0), 0x204, 0x208; resolve taken=1 -> mispredict=1, upd_pc=0x200, occupancy=0, and a same-cycle enqueue is dropped; cnt_mispred=1.
REQ-038: With 3 entries, simultaneous enqueue and correct resolve for 20 cycles -> occupancy stays 3, pointers wrap, FIFO order is preserved.
REQ-039: res_val asserted on an empty queue -> no upd_en, counters unchanged; then async reset asserted mid-fill -> outputs reach reset values without a clock edge.
REQ-040: With CNT_NBITS=4, 17 mispredicting resolves -> cnt_branches=cnt_mispred=15 (saturated).

Source files
------------

// File: rtl/branch_resolve_queue_if.sv
// Predict / resolve / predictor-update handshake bundle for the branch resolve queue.
// The master side is the pipeline front end; the slave side is the queue itself.
interface branch_resolve_queue_if;
    logic        pred_val;
    logic        pred_rdy;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_val;
    logic        res_rdy;
    logic        res_taken;
    logic        upd_en;
    logic        upd_val;
    logic [31:0] upd_pc;
    logic        mispredict;

    modport master (
        output pred_val, pred_pc, pred_taken, res_val, res_taken,
        input  pred_rdy, res_rdy, upd_en, upd_val, upd_pc, mispredict
    );

    modport slave (
        input  pred_val, pred_pc, pred_taken, res_val, res_taken,
        output pred_rdy, res_rdy, upd_en, upd_val, upd_pc, mispredict
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. Resolving the oldest entry produces a registered
// predictor update, and on a mispredict every younger entry is flushed.
module branch_resolve_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_NBITS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_resolve_queue_if.slave    bus,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_NBITS-1:0]     cnt_branches,
    output logic [CNT_NBITS-1:0]     cnt_mispred
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [32:0]      mem [DEPTH];

    logic        enq_fire;
    logic        res_fire;
    logic        mis;
    logic [31:0] head_pc;
    logic        head_taken;

    always_comb begin
        bus.pred_rdy = (occupancy != OCC_FULL);
        bus.res_rdy  = (occupancy != '0);
        head_pc      = mem[head][32:1];
        head_taken   = mem[head][0];
        res_fire     = bus.res_val && bus.res_rdy;
        mis          = res_fire && (bus.res_taken != head_taken);
        // A mispredict flushes the queue, so a same-cycle enqueue is discarded.
        enq_fire     = bus.pred_val && bus.pred_rdy && !mis;
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail] <= {bus.pred_pc, bus.pred_taken};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            occupancy      <= '0;
            bus.upd_en     <= 1'b0;
            bus.upd_val    <= 1'b0;
            bus.upd_pc     <= '0;
            bus.mispredict <= 1'b0;
            cnt_branches   <= '0;
            cnt_mispred    <= '0;
        end else begin
            bus.upd_en     <= res_fire;
            bus.mispredict <= mis;
            if (res_fire) begin
                bus.upd_val <= bus.res_taken;
                bus.upd_pc  <= head_pc;
                if (cnt_branches != '1) begin
                    cnt_branches <= cnt_branches + 1'b1;
                end
                if (mis && (cnt_mispred != '1)) begin
                    cnt_mispred <= cnt_mispred + 1'b1;
                end
            end
            // Flush by collapsing both pointers onto the slot after the resolved head.
            if (mis) begin
                head      <= head + 1'b1;
                tail      <= head + 1'b1;
                occupancy <= '0;
            end else begin
                if (res_fire) begin
                    head <= head + 1'b1;
                end
                if (enq_fire) begin
                    tail <= tail + 1'b1;
                end
                if (enq_fire && !res_fire) begin
                    occupancy <= occupancy + 1'b1;
                end else if (res_fire && !enq_fire) begin
                    occupancy <= occupancy - 1'b1;
                end
            end
        end
    end
endmodule
